fir_axil_ctrl: RTL and testbench



---
 rtl/fir_axil_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_fir_axil_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_axil_ctrl.sv
// Purpose : AXI-Lite responder and control registers (ap_ctrl, data_length, tap RAM port) for the FIR core.
// Latency : write acked (awready/wready) 1 cycle after aw/w seen; read data (rvalid) 1 cycle after arready.
// Backpr. : rvalid/rdata hold until rready; no new address is accepted while a read response is outstanding.
//
// Ports:
//   axis_clk, axis_rst_n             clock, synchronous active-low reset
//   aw*/w*, ar*/r*                   AXI-Lite write-address/data and read-address/data channels (no B channel)
//   tap_WE/EN/Di/A, tap_Do           tap-coefficient BRAM port (1-cycle read latency)
//   ap_start_o, data_length_o        start pulse and programmed sample count towards the core
//   core_tap_EN/A, core_done         core's tap reads (used only while busy) and end-of-run pulse
module fir_axil_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    output logic                   ap_start_o,
    output logic [31:0]            data_length_o,
    input  logic                   core_tap_EN,
    input  logic [pADDR_WIDTH-1:0] core_tap_A,
    input  logic                   core_done
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP0 = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAPE = pADDR_WIDTH'(32 + Tape_Num);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= ADDR_TAP0) && (a < ADDR_TAPE);
    endfunction

    // Register map uses one address per tap; the BRAM is word-addressed in bytes.
    function automatic logic [pADDR_WIDTH-1:0] tap_byte_addr(input logic [pADDR_WIDTH-1:0] a);
        return (a - ADDR_TAP0) << 2;
    endfunction

    state_e                   state_q, state_d;
    logic                     wr_ack_q, wr_ack_d;
    logic [pADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [pDATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                     rd_ack_q, rd_ack_d;
    logic [pADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                     rvalid_q, rvalid_d;
    logic                     rd_tap_first_q, rd_tap_first_d;
    logic                     rd_ctrl_q, rd_ctrl_d;
    logic [pDATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                     ap_done_q, ap_done_d;
    logic [31:0]              data_length_q, data_length_d;

    logic wr_take, rd_take, rd_hs, start_req, ap_idle, done_clear;

    // Writes win over a simultaneous read; nothing new is taken while any access is in flight.
    assign wr_take   = awvalid & wvalid & ~wr_ack_q & ~rd_ack_q & ~rvalid_q;
    assign rd_take   = arvalid & ~(awvalid & wvalid) & ~wr_ack_q & ~rd_ack_q & ~rvalid_q;
    assign rd_hs     = rvalid_q & rready;
    assign start_req = wr_ack_q & (wr_addr_q == ADDR_CTRL) & wr_data_q[0];
    assign ap_idle   = (state_q == S_IDLE);
    // Only clear ap_done if the value actually handed to the host carried it,
    // so a done that lands between capture and handshake is not lost.
    assign done_clear = rd_hs & rd_ctrl_q & rdata_q[1];

    assign awready       = wr_ack_q;
    assign wready        = wr_ack_q;
    assign arready       = rd_ack_q;
    assign rvalid        = rvalid_q;
    assign data_length_o = data_length_q;
    // The BRAM output is only guaranteed in the first response cycle; after that the captured copy holds it.
    assign rdata         = rd_tap_first_q ? tap_Do : rdata_q;

    // Run-state FSM: next state and start pulse.
    always_comb begin
        state_d    = state_q;
        ap_start_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d    = S_BUSY;
                    ap_start_o = 1'b1;
                end
            end
            S_BUSY: begin
                if (core_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake, register and read-capture next state.
    always_comb begin
        wr_ack_d       = wr_take;
        wr_addr_d      = wr_take ? awaddr : wr_addr_q;
        wr_data_d      = wr_take ? wdata  : wr_data_q;
        rd_ack_d       = rd_take;
        rd_addr_d      = rd_take ? araddr : rd_addr_q;
        rvalid_d       = rvalid_q;
        rd_tap_first_d = 1'b0;
        rd_ctrl_d      = rd_ctrl_q;
        rdata_d        = rdata_q;
        ap_done_d      = ap_done_q;
        data_length_d  = data_length_q;

        if (rd_ack_q) begin
            rvalid_d = 1'b1;
        end else if (rd_hs) begin
            rvalid_d = 1'b0;
        end

        if (rd_ack_q) begin
            rd_ctrl_d = (rd_addr_q == ADDR_CTRL);
            if (rd_addr_q == ADDR_CTRL) begin
                rdata_d = {{(pDATA_WIDTH-3){1'b0}}, ap_idle, ap_done_q, ap_start_o};
            end else if (rd_addr_q == ADDR_LEN) begin
                rdata_d = pDATA_WIDTH'(data_length_q);
            end else if (is_tap(rd_addr_q)) begin
                // While busy the core owns the RAM, so the host gets all-ones instead.
                rdata_d        = ap_idle ? '0 : '1;
                rd_tap_first_d = ap_idle;
            end else begin
                rdata_d = '0;
            end
        end else if (rd_tap_first_q) begin
            rdata_d = tap_Do;
        end

        if (wr_ack_q && (wr_addr_q == ADDR_LEN) && ap_idle) begin
            data_length_d = 32'(wr_data_q);
        end

        // Priority: set on core_done beats any clear in the same cycle.
        if (done_clear) begin
            ap_done_d = 1'b0;
        end
        if (ap_idle && start_req) begin
            ap_done_d = 1'b0;
        end
        if (!ap_idle && core_done) begin
            ap_done_d = 1'b1;
        end
    end

    // Tap port ownership: core while busy, AXI-Lite side otherwise.
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (state_q == S_BUSY) begin
            tap_EN = core_tap_EN;
            tap_A  = core_tap_A;
        end else if (wr_ack_q && is_tap(wr_addr_q)) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = tap_byte_addr(wr_addr_q);
            tap_Di = wr_data_q;
        end else if (rd_ack_q && is_tap(rd_addr_q)) begin
            tap_EN = 1'b1;
            tap_A  = tap_byte_addr(rd_addr_q);
        end
        // Keep a write that was in flight when reset arrived from reaching the RAM.
        tap_EN = tap_EN & axis_rst_n;
        tap_WE = tap_WE & {4{axis_rst_n}};
    end

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state_q        <= S_IDLE;
            wr_ack_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            rd_ack_q       <= 1'b0;
            rd_addr_q      <= '0;
            rvalid_q       <= 1'b0;
            rd_tap_first_q <= 1'b0;
            rd_ctrl_q      <= 1'b0;
            rdata_q        <= '0;
            ap_done_q      <= 1'b0;
            data_length_q  <= '0;
        end else begin
            state_q        <= state_d;
            wr_ack_q       <= wr_ack_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            rd_ack_q       <= rd_ack_d;
            rd_addr_q      <= rd_addr_d;
            rvalid_q       <= rvalid_d;
            rd_tap_first_q <= rd_tap_first_d;
            rd_ctrl_q      <= rd_ctrl_d;
            rdata_q        <= rdata_d;
            ap_done_q      <= ap_done_d;
            data_length_q  <= data_length_d;
        end
    end

endmodule

// File: tb/tb_fir_axil_ctrl.sv
// Purpose : directed self-checking bench for fir_axil_ctrl with a behavioural 1-cycle tap BRAM.
// Latency : checks arready->rvalid spacing and write-ack timing against hand-computed values.
// Backpr. : exercises rready held low and write/read collisions.
module tb_fir_axil_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0;
    logic        awready, wready, arready, rvalid;
    logic [31:0] rdata;
    logic [3:0]  tap_WE;
    logic        tap_EN;
    logic [31:0] tap_Di;
    logic [11:0] tap_A;
    logic [31:0] tap_Do = '0;
    logic        ap_start_o;
    logic [31:0] data_length_o;
    logic        core_tap_EN = 1'b0;
    logic [11:0] core_tap_A = '0;
    logic        core_done = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:15];
    int taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    logic [31:0] rd;
    logic        st;
    logic [3:0]  we;
    logic        got, saw_ar;

    fir_axil_ctrl dut (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .ap_start_o(ap_start_o), .data_length_o(data_length_o),
        .core_tap_EN(core_tap_EN), .core_tap_A(core_tap_A), .core_done(core_done)
    );

    always #5 clk = ~clk;

    // bram11-style tap RAM: byte enables, registered read.
    always @(posedge clk) begin
        if (tap_EN) begin
            for (int b = 0; b < 4; b++) begin
                if (tap_WE[b]) mem[tap_A[5:2]][8*b +: 8] <= tap_Di[8*b +: 8];
            end
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d,
                             output logic start_seen, output logic [3:0] we_seen);
        logic ok;
        ok = 1'b0;
        start_seen = 1'b0;
        we_seen = 4'h0;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (awready && wready) begin
                ok = 1'b1;
                start_seen = ap_start_o;
                we_seen = tap_WE;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!ok) check("wr_timeout", 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [11:0] a, output logic [31:0] d);
        logic ok;
        ok = 1'b0;
        d = '1;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (arready) ok = 1'b1;
        end
        arvalid = 1'b0;
        if (!ok) begin
            check("rd_timeout", 32'(ok), 32'd1);
        end else begin
            @(posedge clk); #1;
            check("rd_latency", 32'(rvalid), 32'd1);
            d = rdata;
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(awready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_start", 32'(ap_start_o), 0);
        check("rst_tap_en", 32'(tap_EN), 0);
        check("rst_tap_we", 32'(tap_WE), 0);
        check("rst_rdata", rdata, 0);
        check("rst_len", data_length_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        axi_read(12'h000, rd);
        check("ctrl_after_reset", rd, 32'h4);

        // Program length and taps, read back
        axi_write(12'h010, 32'd600, st, we);
        check("len_out", data_length_o, 32'd600);
        for (int k = 0; k < 11; k++) begin
            axi_write(12'(32 + k), 32'(taps[k]), st, we);
            check("tap_we", 32'(we), 32'hF);
        end
        for (int k = 0; k < 11; k++) begin
            axi_read(12'(32 + k), rd);
            check($sformatf("tap%0d", k), rd, 32'(taps[k]));
        end
        axi_read(12'h010, rd);
        check("len_read", rd, 32'd600);
        axi_write(12'h040, 32'h5A5A5A5A, st, we);
        check("unmapped_we", 32'(we), 0);
        axi_read(12'h040, rd);
        check("unmapped_read", rd, 0);

        // Start a run
        axi_write(12'h000, 32'h1, st, we);
        check("start_pulse", 32'(st), 1);
        check("start_one_cycle", 32'(ap_start_o), 0);
        axi_read(12'h000, rd);
        check("ctrl_busy", rd, 32'h0);

        // Core owns the tap port while busy
        core_tap_EN = 1'b1; core_tap_A = 12'h014; #1;
        check("mux_en", 32'(tap_EN), 1);
        check("mux_a", 32'(tap_A), 32'h14);
        check("mux_we", 32'(tap_WE), 0);
        core_tap_EN = 1'b0;

        // Busy protection
        axi_write(12'h025, 32'd99, st, we);
        check("busy_tap_we", 32'(we), 0);
        axi_read(12'h025, rd);
        check("busy_tap_read", rd, 32'hFFFFFFFF);
        axi_write(12'h010, 32'd5, st, we);
        check("busy_len", data_length_o, 32'd600);
        axi_write(12'h000, 32'h1, st, we);
        check("busy_restart", 32'(st), 0);

        // Finish the run
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        axi_read(12'h000, rd);
        check("ctrl_done", rd, 32'h6);
        axi_read(12'h000, rd);
        check("ctrl_done_cleared", rd, 32'h4);
        axi_read(12'h025, rd);
        check("tap5_unchanged", rd, 32'd63);

        // Collision: write wins, read follows, rready held low
        awaddr = 12'h021; wdata = 32'h0000_1234; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 12'h021; arvalid = 1'b1;
        got = 1'b0; saw_ar = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (arready) saw_ar = 1'b1;
            if (awready && wready) got = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("coll_wr_ack", 32'(got), 1);
        check("coll_wr_first", 32'(saw_ar), 0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (arready) got = 1'b1;
        end
        arvalid = 1'b0;
        check("coll_rd_ack", 32'(got), 1);
        @(posedge clk); #1;
        check("coll_rvalid", 32'(rvalid), 1);
        check("coll_rdata", rdata, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_rvalid", 32'(rvalid), 1);
            check("hold_rdata", rdata, 32'h1234);
            check("hold_arready", 32'(arready), 0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("hold_release", 32'(rvalid), 0);

        // core_done coinciding with a 0x00 read handshake
        axi_write(12'h000, 32'h1, st, we);
        check("start2", 32'(st), 1);
        araddr = 12'h000; arvalid = 1'b1; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (arready) got = 1'b1;
        end
        arvalid = 1'b0;
        check("race_rd_ack", 32'(got), 1);
        @(posedge clk); #1;
        check("race_rdata", rdata, 32'h0);
        rready = 1'b1; core_done = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; core_done = 1'b0;
        axi_read(12'h000, rd);
        check("race_done_kept", rd, 32'h6);
        axi_read(12'h000, rd);
        check("race_done_cleared", rd, 32'h4);

        // Reset during BUSY with a write in flight
        axi_write(12'h000, 32'h1, st, we);
        core_tap_EN = 1'b1; core_tap_A = 12'h008;
        awaddr = 12'h022; wdata = 32'd7; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_busy_awready", 32'(awready), 0);
        check("rst_busy_start", 32'(ap_start_o), 0);
        check("rst_busy_tap_en", 32'(tap_EN), 0);
        check("rst_busy_tap_we", 32'(tap_WE), 0);
        awvalid = 1'b0; wvalid = 1'b0; core_tap_EN = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        axi_read(12'h000, rd);
        check("rst_busy_ctrl", rd, 32'h4);
        axi_read(12'h010, rd);
        check("rst_busy_len", rd, 32'h0);
        axi_read(12'h022, rd);
        check("rst_busy_tap2", rd, 32'hFFFFFFF7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
